// File: rtl/ddr_arb_pkg.sv
// Shared types and default widths for the DDR3 port arbiter.
package ddr_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 27;
  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned MASK_W_DEF = 8;

  // Encoding matches the alexMemEnable field of the DDR3 top.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    VID = 1'b0,
    CPU = 1'b1
  } owner_e;

endpackage

// File: rtl/ddr_port_arbiter.sv
// Two-requester arbiter (video reads, cache read/write) for the single DDR3 alex* port.
// One transaction at a time: grant in IDLE, command handshake, data phase, done pulse.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned MASK_W        = MASK_W_DEF,
  parameter int unsigned VID_BURST_MAX = 4,
  parameter int unsigned TIMEOUT       = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_done,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [MASK_W-1:0] cpu_wbytes,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] alexAddress,
  output logic [DATA_W-1:0] alexWriteData,
  output logic [MASK_W-1:0] alexWriteBytes,
  output logic [1:0]        alexMemEnable,
  output logic              alexNewCommand,
  input  logic              alexFinishedCommand,
  input  logic              alexFinishedMemAction,
  input  logic [DATA_W-1:0] alexReadData,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned STRK_W = $clog2(VID_BURST_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(VID_BURST_MAX);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, grant_owner;
  mem_op_e           op_q, op_d, grant_op;
  logic [STRK_W-1:0] streak_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic              grant, capture, abort, timed_out;

  // Video wins contention until it has taken VID_BURST_MAX grants in a row.
  function automatic owner_e pick_owner(input logic v, input logic c,
                                        input logic [STRK_W-1:0] streak);
    if (v && (!c || streak != STRK_MAX)) return VID;
    return CPU;
  endfunction

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    grant_owner = pick_owner(vid_req, cpu_req, streak_q);
    grant_op    = (grant_owner == CPU && cpu_we) ? WR : RD;
    timed_out   = (tmo_cnt_q == CNT_LAST);
    case (state_q)
      ST_IDLE: begin
        if (vid_req || cpu_req) begin
          grant   = 1'b1;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (alexFinishedCommand) begin
          capture = alexFinishedMemAction;
          state_d = alexFinishedMemAction ? ST_DONE : ST_DATA;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DATA: begin
        if (alexFinishedMemAction) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (timed_out) begin
          abort   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    op_d = grant ? grant_op : op_q;
  end

  assign busy = (state_q != ST_IDLE);

  // alex* and done outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      owner_q        <= VID;
      op_q           <= IDLE;
      streak_q       <= '0;
      tmo_cnt_q      <= '0;
      alexAddress    <= '0;
      alexWriteData  <= '0;
      alexWriteBytes <= '0;
      alexMemEnable  <= '0;
      alexNewCommand <= 1'b0;
      vid_done       <= 1'b0;
      cpu_done       <= 1'b0;
      vid_rdata      <= '0;
      cpu_rdata      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (state_q == ST_IDLE) begin
        if (grant && grant_owner == VID && cpu_req)
          streak_q <= (streak_q == STRK_MAX) ? streak_q : streak_q + 1'b1;
        else
          streak_q <= '0;
      end
      if (grant) begin
        owner_q        <= grant_owner;
        alexAddress    <= (grant_owner == VID) ? vid_addr : cpu_addr;
        alexWriteData  <= (grant_op == WR) ? cpu_wdata : '0;
        alexWriteBytes <= (grant_op == WR) ? cpu_wbytes : '0;
      end
      if ((state_d == ST_CMD && state_q != ST_CMD) ||
          (state_q == ST_CMD && state_d == ST_DATA))
        tmo_cnt_q <= '0;
      else if (state_q == ST_CMD || state_q == ST_DATA)
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      alexNewCommand <= (state_d == ST_CMD);
      alexMemEnable  <= (state_d == ST_CMD) ? op_d : IDLE;
      vid_done       <= (state_d == ST_DONE) && (owner_q == VID);
      cpu_done       <= (state_d == ST_DONE) && (owner_q == CPU);
      if (abort) timeout_err <= 1'b1;
      if (capture && op_q == RD) begin
        if (owner_q == VID) vid_rdata <= alexReadData;
        else                cpu_rdata <= alexReadData;
      end
    end
  end

endmodule
